// File: rtl/tcni_rx_dma.sv
// Receive DMA for the TCNI: takes header, size and payload flits from the
// local NoC port and writes payload flits to consecutive packet-memory words.
module tcni_rx_dma #(
    parameter int unsigned FLIT_W        = 32,
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned ADDR_STEP     = 4,
    parameter int unsigned MAX_PKT_FLITS = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [FLIT_W-1:0] noc_rx_data,
    input  logic              noc_rx_valid,
    output logic              noc_rx_ready,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [FLIT_W-1:0] mem_wdata,
    input  logic              cpu_arm,
    input  logic [ADDR_W-1:0] cpu_base,
    input  logic              cpu_ack,
    output logic              rx_busy,
    output logic              rx_done,
    output logic [FLIT_W-1:0] rx_hdr,
    output logic [15:0]       rx_size,
    output logic              rx_trunc
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W:0]    MAX_K = (CNT_W+1)'(MAX_PKT_FLITS);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(ADDR_STEP);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_HDR  = 3'd1,
        WAIT_SIZE = 3'd2,
        PAYLOAD   = 3'd3,
        FLUSH     = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  base;
    logic [ADDR_W-1:0]  wr_addr;
    logic [CNT_W-1:0]   k;
    logic               xfer;
    logic               arm_go;
    logic               under_max;

    // Handshake, arm qualification and truncation window
    always_comb begin
        xfer      = noc_rx_valid & noc_rx_ready;
        arm_go    = cpu_arm & ((state == IDLE) | ((state == DONE) & cpu_ack));
        under_max = ({1'b0, k} < MAX_K);
    end

    // Packet FSM; ready/busy/done are registered alongside the state they reflect
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            base         <= '0;
            wr_addr      <= '0;
            k            <= '0;
            noc_rx_ready <= 1'b0;
            mem_wr_en    <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            rx_busy      <= 1'b0;
            rx_done      <= 1'b0;
            rx_hdr       <= '0;
            rx_size      <= '0;
            rx_trunc     <= 1'b0;
        end else begin
            mem_wr_en <= 1'b0;
            if (arm_go) begin
                state        <= WAIT_HDR;
                base         <= cpu_base;
                rx_trunc     <= 1'b0;
                rx_hdr       <= '0;
                rx_size      <= '0;
                noc_rx_ready <= 1'b1;
                rx_busy      <= 1'b1;
                rx_done      <= 1'b0;
            end else begin
                case (state)
                    WAIT_HDR: begin
                        if (xfer) begin
                            rx_hdr <= noc_rx_data;
                            state  <= WAIT_SIZE;
                        end
                    end
                    WAIT_SIZE: begin
                        if (xfer) begin
                            rx_size <= noc_rx_data[15:0];
                            k       <= '0;
                            wr_addr <= base;
                            if (noc_rx_data[15:0] == 16'd0) begin
                                state        <= FLUSH;
                                noc_rx_ready <= 1'b0;
                            end else begin
                                state <= PAYLOAD;
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (xfer) begin
                            k <= CNT_W'(k + 16'd1);
                            if (under_max) begin
                                mem_wr_en <= 1'b1;
                                mem_addr  <= wr_addr;
                                mem_wdata <= noc_rx_data;
                                wr_addr   <= ADDR_W'(wr_addr + STEP);
                            end else begin
                                rx_trunc <= 1'b1;
                            end
                            if (k == CNT_W'(rx_size - 16'd1)) begin
                                state        <= FLUSH;
                                noc_rx_ready <= 1'b0;
                            end
                        end
                    end
                    FLUSH: begin
                        state   <= DONE;
                        rx_busy <= 1'b0;
                        rx_done <= 1'b1;
                    end
                    DONE: begin
                        if (cpu_ack) begin
                            state   <= IDLE;
                            rx_done <= 1'b0;
                        end
                    end
                    default: begin
                        state        <= IDLE;
                        noc_rx_ready <= 1'b0;
                        rx_busy      <= 1'b0;
                        rx_done      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tcni_rx_dma.sv
// Self-checking bench for tcni_rx_dma: packet vector table plus directed
// sequences for unarmed traffic, DONE-state arm/ack and mid-packet reset.
module tb_tcni_rx_dma;

    localparam int unsigned MAXF = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] noc_rx_data = '0;
    logic        noc_rx_valid = 1'b0;
    logic        noc_rx_ready;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_arm = 1'b0;
    logic [31:0] cpu_base = '0;
    logic        cpu_ack = 1'b0;
    logic        rx_busy;
    logic        rx_done;
    logic [31:0] rx_hdr;
    logic [15:0] rx_size;
    logic        rx_trunc;

    tcni_rx_dma #(
        .FLIT_W(32), .ADDR_W(32), .ADDR_STEP(4), .MAX_PKT_FLITS(MAXF)
    ) dut (
        .clock(clock), .reset(reset),
        .noc_rx_data(noc_rx_data), .noc_rx_valid(noc_rx_valid), .noc_rx_ready(noc_rx_ready),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_arm(cpu_arm), .cpu_base(cpu_base), .cpu_ack(cpu_ack),
        .rx_busy(rx_busy), .rx_done(rx_done), .rx_hdr(rx_hdr),
        .rx_size(rx_size), .rx_trunc(rx_trunc)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] base;
        logic [31:0] hdr;
        logic [15:0] size;
        logic [7:0]  gap;        // bit i: one idle cycle before payload i
        int          exp_writes;
        logic [31:0] exp_last;
        logic        exp_trunc;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    int unsigned wq_cyc[$];

    always @(posedge clock) cyc <= cyc + 1;

    // Capture every memory write away from the active edge
    always @(negedge clock) begin
        if (mem_wr_en === 1'b1) begin
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_wdata);
            wq_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_wq();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
    endtask

    task automatic send_flit(input logic [31:0] d);
        logic was;
        bit   ok;
        ok = 0;
        noc_rx_valid = 1'b1;
        noc_rx_data  = d;
        for (int n = 0; n < 20; n++) begin
            was = noc_rx_ready;
            tick();
            if (was === 1'b1) begin
                ok = 1;
                break;
            end
        end
        noc_rx_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL flit_accept actual=not_accepted required=accepted data=0x%08h", d);
        end
    endtask

    task automatic arm(input logic [31:0] b);
        cpu_arm  = 1'b1;
        cpu_base = b;
        tick();
        cpu_arm  = 1'b0;
        chk("arm_ready", 32'(noc_rx_ready), 32'd1);
        chk("arm_busy", 32'(rx_busy), 32'd1);
    endtask

    task automatic ack();
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
        chk("ack_done", 32'(rx_done), 32'd0);
    endtask

    // Everything after arming: send the packet and check the results
    task automatic run_body(input vec_t v);
        int unsigned d;
        clear_wq();
        send_flit(v.hdr);
        send_flit({16'hBEEF, v.size});
        for (int i = 0; i < int'(v.size); i++) begin
            if (i < 8 && v.gap[i]) tick();
            send_flit(32'hD000_0000 + 32'(i));
        end
        chk("done_early", 32'(rx_done), 32'd0);
        tick();
        chk("done_late", 32'(rx_done), 32'd1);
        chk("busy_in_done", 32'(rx_busy), 32'd0);
        chk("ready_in_done", 32'(noc_rx_ready), 32'd0);
        chk("num_writes", 32'(wq_addr.size()), 32'(v.exp_writes));
        for (int i = 0; i < wq_addr.size() && i < v.exp_writes; i++) begin
            chk("wr_addr", wq_addr[i], v.base + 32'(i) * 32'd4);
            chk("wr_data", wq_data[i], 32'hD000_0000 + 32'(i));
            if (i > 0) begin
                d = wq_cyc[i] - wq_cyc[i-1];
                chk("wr_spacing", 32'(d), 32'd1 + ((i < 8) ? 32'(v.gap[i]) : 32'd0));
            end
        end
        if (v.exp_writes > 0 && wq_addr.size() > 0)
            chk("last_addr", wq_addr[wq_addr.size()-1], v.exp_last);
        chk("rx_hdr", rx_hdr, v.hdr);
        chk("rx_size", 32'(rx_size), 32'(v.size));
        chk("rx_trunc", 32'(rx_trunc), 32'(v.exp_trunc));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(noc_rx_ready), 32'd0);
        chk({tag, "_wr_en"}, 32'(mem_wr_en), 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_busy"}, 32'(rx_busy), 32'd0);
        chk({tag, "_done"}, 32'(rx_done), 32'd0);
        chk({tag, "_hdr"}, rx_hdr, 32'd0);
        chk({tag, "_size"}, 32'(rx_size), 32'd0);
        chk({tag, "_trunc"}, 32'(rx_trunc), 32'd0);
    endtask

    initial begin
        vec_t vecs[5];
        vec_t v;
        vecs[0] = '{32'h0000_1000, 32'h0023_0011, 16'd3, 8'b0000_0000, 3, 32'h0000_1008, 1'b0};
        vecs[1] = '{32'h0000_3000, 32'h0000_00AA, 16'd4, 8'b0000_1010, 4, 32'h0000_300C, 1'b0};
        vecs[2] = '{32'h0000_4000, 32'h0000_0BB0, 16'd0, 8'b0000_0000, 0, 32'h0000_0000, 1'b0};
        vecs[3] = '{32'h0000_5000, 32'h0000_0CC0, 16'd6, 8'b0010_0000, 4, 32'h0000_500C, 1'b1};
        vecs[4] = '{32'hFFFF_FFFC, 32'h0000_0DD0, 16'd2, 8'b0000_0010, 2, 32'h0000_0000, 1'b0};

        // Reset state
        reset = 1'b0;
        repeat (3) tick();
        chk_all_zero("rst");
        reset = 1'b1;
        tick();

        // Valid held high while unarmed: never accepted, nothing written
        clear_wq();
        noc_rx_valid = 1'b1;
        noc_rx_data  = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("unarmed_ready", 32'(noc_rx_ready), 32'd0);
        end
        noc_rx_valid = 1'b0;
        chk("unarmed_writes", 32'(wq_addr.size()), 32'd0);

        // Packet table
        for (int t = 0; t < 5; t++) begin
            arm(vecs[t].base);
            run_body(vecs[t]);
            ack();
        end

        // DONE: arm alone ignored, then arm together with ack re-arms
        arm(32'h0000_8000);
        v = '{32'h0000_8000, 32'h0000_0EE0, 16'd1, 8'h00, 1, 32'h0000_8000, 1'b0};
        run_body(v);
        cpu_arm  = 1'b1;
        cpu_base = 32'h9999_0000;
        tick();
        cpu_arm  = 1'b0;
        chk("arm_only_done", 32'(rx_done), 32'd1);
        chk("arm_only_ready", 32'(noc_rx_ready), 32'd0);
        cpu_ack  = 1'b1;
        cpu_arm  = 1'b1;
        cpu_base = 32'h0000_2000;
        tick();
        cpu_ack  = 1'b0;
        cpu_arm  = 1'b0;
        chk("ackarm_done", 32'(rx_done), 32'd0);
        chk("ackarm_busy", 32'(rx_busy), 32'd1);
        chk("ackarm_ready", 32'(noc_rx_ready), 32'd1);
        v = '{32'h0000_2000, 32'h0000_0FF0, 16'd2, 8'h00, 2, 32'h0000_2004, 1'b0};
        run_body(v);
        ack();

        // Reset after 2 of 5 payload flits aborts the packet
        clear_wq();
        arm(32'h0000_6000);
        send_flit(32'h0000_0123);
        send_flit(32'h0000_0005);
        send_flit(32'hD000_0000);
        send_flit(32'hD000_0001);
        reset = 1'b0;
        tick();
        chk_all_zero("midrst");
        reset = 1'b1;
        chk("midrst_writes", 32'(wq_addr.size()), 32'd2);
        noc_rx_valid = 1'b1;
        noc_rx_data  = 32'hD000_0002;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_ready", 32'(noc_rx_ready), 32'd0);
        end
        noc_rx_valid = 1'b0;
        chk("post_rst_writes", 32'(wq_addr.size()), 32'd2);
        arm(32'h0000_7000);
        v = '{32'h0000_7000, 32'h0000_0456, 16'd2, 8'h00, 2, 32'h0000_7004, 1'b0};
        run_body(v);
        ack();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop if something stalls beyond every bounded wait
    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
